mdio_controller: RTL



---
 rtl/mdio_controller_pkg.sv | 39 +++
 rtl/mdio_controller_if.sv | 26 ++
 rtl/mdio_controller_mdc_gen.sv | 37 +++
 rtl/mdio_controller.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mdio_controller_pkg.sv
// MDIO controller shared definitions
// Frame layout, opcodes and FSM state encoding
package mdio_controller_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST_CL22  = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // last bit index still driven on a read frame
  localparam logic [4:0] RD_OE_LAST = 5'd18;
  // first bit index captured on a read frame
  localparam logic [4:0] RD_CAP_TOP = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_FRAME,
    S_DONE
  } mdio_state_t;

  function automatic logic is_read(input logic [31:0] f);
    return f[OP_MSB:OP_LSB] == OP_READ;
  endfunction

endpackage

// File: rtl/mdio_controller_if.sv
// MDIO controller bundle: host request/response and MDIO pins
// slave = controller side, master = host/PHY side
interface mdio_controller_if;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        MDIO_DONE;
  logic        BUSY;

  modport slave (
    input  MDIO_START, T_DATA, MDIO_IN,
    output MDC, MDIO_OUT, MDIO_OE,
    output RD_DATA, DATA_RDY, MDIO_DONE, BUSY
  );

  modport master (
    output MDIO_START, T_DATA, MDIO_IN,
    input  MDC, MDIO_OUT, MDIO_OE,
    input  RD_DATA, DATA_RDY, MDIO_DONE, BUSY
  );
endinterface

// File: rtl/mdio_controller_mdc_gen.sv
// MDC generator: half-period counter and bit-window strobes
// Held at window start (MDC low) while disabled
module mdio_mdc_gen #(
  parameter int DIV_HALF = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_en,
  output logic o_mdc,
  output logic o_bit_start,
  output logic o_bit_sample
);

  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  // count half periods; phase flips at the end of each half
  always_ff @(posedge CLK) begin
    if (RESET || !i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_mdc        = r_phase;
  assign o_bit_start  = i_en && !r_phase && (r_cnt == '0);
  assign o_bit_sample = i_en && r_phase && (r_cnt == LAST);

endmodule

// File: rtl/mdio_controller.sv
// MDIO station-management controller
// Preamble + 32-bit frame out, 16-bit read capture
module mdio_controller
  import mdio_controller_pkg::*;
#(
  parameter int PRE_LEN  = 32,
  parameter int DIV_HALF = 1
) (
  input logic              CLK,
  input logic              RESET,
  mdio_controller_if.slave bus
);

  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

  mdio_state_t r_state;
  logic [31:0] r_shift;
  logic        r_rd;
  logic [4:0]  r_bit;
  logic [PW-1:0] r_pre;
  logic [15:0] r_stage;
  logic [15:0] r_rd_data;
  logic        r_out;
  logic        r_oe;
  logic        r_busy;
  logic        r_done;
  logic        r_rdy;

  logic        w_en;
  logic        w_mdc;
  logic        w_bit_start;
  logic        w_sample;
  logic [4:0]  w_nbit;
  logic        w_noe;
  logic [15:0] w_stage_nx;

  assign w_en       = (r_state == S_PRE) || (r_state == S_FRAME);
  assign w_nbit     = r_bit - 5'd1;
  assign w_noe      = !r_rd || (w_nbit >= RD_OE_LAST);
  assign w_stage_nx = {r_stage[14:0], bus.MDIO_IN};

  mdio_mdc_gen #(
    .DIV_HALF (DIV_HALF)
  ) u_mdc (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_en         (w_en),
    .o_mdc        (w_mdc),
    .o_bit_start  (w_bit_start),
    .o_bit_sample (w_sample)
  );

  // frame FSM; all pin and status outputs are registered here
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_rd      <= 1'b0;
      r_bit     <= '0;
      r_pre     <= '0;
      r_stage   <= '0;
      r_rd_data <= '0;
      r_out     <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.MDIO_START) begin
            r_shift <= bus.T_DATA;
            r_rd    <= is_read(bus.T_DATA);
            r_busy  <= 1'b1;
            r_oe    <= 1'b1;
            r_bit   <= 5'd31;
            r_stage <= '0;
            if (PRE_LEN != 0) begin
              r_state <= S_PRE;
              r_out   <= 1'b1;
              r_pre   <= PW'(PRE_LEN - 1);
            end else begin
              r_state <= S_FRAME;
              r_out   <= bus.T_DATA[31];
            end
          end
        end
        S_PRE: begin
          if (w_sample) begin
            if (r_pre == '0) begin
              r_state <= S_FRAME;
              r_out   <= r_shift[31];
            end else begin
              r_pre <= r_pre - PW'(1);
            end
          end
        end
        S_FRAME: begin
          if (w_sample) begin
            if (r_rd && (r_bit <= RD_CAP_TOP))
              r_stage <= w_stage_nx;
            if (r_bit == 5'd0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_oe    <= 1'b0;
              r_out   <= 1'b0;
              r_done  <= 1'b1;
              if (r_rd) begin
                r_rd_data <= w_stage_nx;
                r_rdy     <= 1'b1;
              end
            end else begin
              r_bit   <= w_nbit;
              r_shift <= {r_shift[30:0], 1'b0};
              r_oe    <= w_noe;
              r_out   <= w_noe & r_shift[30];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_rdy   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // a bit window always opens with MDC low
  always_ff @(posedge CLK) begin
    if (!RESET && w_bit_start)
      assert (!w_mdc);
  end

  assign bus.MDC       = w_mdc;
  assign bus.MDIO_OUT  = r_out;
  assign bus.MDIO_OE   = r_oe;
  assign bus.RD_DATA   = r_rd_data;
  assign bus.DATA_RDY  = r_rdy;
  assign bus.MDIO_DONE = r_done;
  assign bus.BUSY      = r_busy;

endmodule
